// File: rtl/ro_sample_sched.sv
// Measurement-window scheduler for the ring-oscillator power sensor: clear, run window, settle, capture.
// Optional feature macro: RO_SCHED_SEQNUM_EN adds a 16-bit sample_seq output.
module ro_sample_sched #(
    parameter int WINDOW_W   = 16,
    parameter int SUM_W      = 36,
    parameter int SETTLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                continuous,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic [SUM_W-1:0]    tree_sum,
    output logic                ro_clr,
    output logic                ro_en,
    output logic [SUM_W-1:0]    sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
`ifdef RO_SCHED_SEQNUM_EN
    output logic [15:0]         sample_seq,
`endif
    output logic                overrun
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    // One down-counter serves both the window and the settle interval.
    localparam int CNT_W = (WINDOW_W > 4) ? WINDOW_W : 4;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] win_eff;
    logic [SUM_W-1:0] sample_reg;
    logic             valid_reg, valid_next;
    logic             overrun_reg, overrun_next;
    logic             capture_load;

    assign win_eff = (window_len == '0) ? CNT_W'(1) : CNT_W'(window_len);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // window_len is only looked at here; later changes cannot stretch the window.
                cnt_next   = win_eff;
                state_next = S_RUN;
            end
            S_RUN: begin
                if (cnt_reg == CNT_W'(1)) begin
                    cnt_next   = CNT_W'(SETTLE_CYC);
                    state_next = S_SETTLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_reg == CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = S_CAPTURE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                state_next = continuous ? S_CLEAR : S_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // A capture may overwrite the held sample only if it is empty or leaving this very cycle.
    assign capture_load = (state_reg == S_CAPTURE) && (!valid_reg || sample_ready);

    always_comb begin
        valid_next = valid_reg;
        if (capture_load) begin
            valid_next = 1'b1;
        end else if (valid_reg && sample_ready) begin
            valid_next = 1'b0;
        end
    end

    always_comb begin
        overrun_next = overrun_reg;
        if (state_reg == S_IDLE && start) begin
            overrun_next = 1'b0;
        end else if (state_reg == S_CAPTURE && !capture_load) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            sample_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
            if (capture_load) begin
                sample_reg <= tree_sum;
            end
        end
    end

`ifdef RO_SCHED_SEQNUM_EN
    // Advances on every capture, dropped ones included, so gaps reveal overruns.
    logic [15:0] seq_cnt_reg;
    logic [15:0] sample_seq_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_cnt_reg    <= '0;
            sample_seq_reg <= '0;
        end else begin
            if (state_reg == S_CAPTURE) begin
                seq_cnt_reg <= seq_cnt_reg + 16'd1;
            end
            if (capture_load) begin
                sample_seq_reg <= seq_cnt_reg;
            end
        end
    end

    assign sample_seq = sample_seq_reg;
`endif

    assign ro_clr       = (state_reg == S_CLEAR);
    assign ro_en        = (state_reg == S_RUN);
    assign busy         = (state_reg != S_IDLE);
    assign sample       = sample_reg;
    assign sample_valid = valid_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_ro_sample_sched.sv
// Randomized scoreboard bench for ro_sample_sched; window schedule is derived arithmetically
// from the start cycle, window length and settle count.
module tb_ro_sample_sched;

    localparam int WW = 16;
    localparam int SW = 36;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic [SW-1:0] tree_sum;
    logic          sample_ready = 1'b0;
    logic          ro_clr, ro_en, sample_valid, busy, overrun;
    logic [SW-1:0] sample;
`ifdef RO_SCHED_SEQNUM_EN
    logic [15:0]   sample_seq;
`endif

    always #5 clk = ~clk;

    ro_sample_sched #(.WINDOW_W(WW), .SUM_W(SW), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .window_len(window_len), .tree_sum(tree_sum), .ro_clr(ro_clr), .ro_en(ro_en),
        .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .busy(busy),
`ifdef RO_SCHED_SEQNUM_EN
        .sample_seq(sample_seq),
`endif
        .overrun(overrun)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // tree_sum differs every cycle, so a capture one cycle early or late shows up as wrong data.
    function automatic logic [SW-1:0] fsum(input int c);
        logic [31:0] x;
        x = c * 32'h9E3779B1;
        return {4'(c * 5), x};
    endfunction

    assign tree_sum = fsum(cyc);

    typedef struct {
        logic [SW-1:0] data;
        logic [15:0]   seq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Per-cycle expectations published by the stimulus process, consumed by the monitor.
    int   exp_cyc = -1;
    logic exp_clr = 0, exp_en = 0, exp_busy = 0, exp_valid = 0, exp_ovr = 0, exp_zero = 0;

    logic          m_pending = 0;
    logic          m_ovr = 0;
    logic [15:0]   m_seq = 0;

    logic          prev_hold = 0;
    logic [SW-1:0] prev_sample = '0;

    always @(negedge clk) begin
        if (exp_cyc == cyc) begin
            check("ro_clr", 64'(ro_clr), 64'(exp_clr));
            check("ro_en", 64'(ro_en), 64'(exp_en));
            check("busy", 64'(busy), 64'(exp_busy));
            check("sample_valid", 64'(sample_valid), 64'(exp_valid));
            check("overrun", 64'(overrun), 64'(exp_ovr));
            if (exp_zero) check("sample_after_reset", 64'(sample), 64'd0);
            if (prev_hold) check("sample_stable", 64'(sample), 64'(prev_sample));
            if (sample_valid && sample_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_transfer cycle %0d: got sample %0h expected no transfer", cyc, sample);
                end else begin
                    mon_e = sb.pop_front();
                    check("sample_data", 64'(sample), 64'(mon_e.data));
`ifdef RO_SCHED_SEQNUM_EN
                    check("sample_seq", 64'(sample_seq), 64'(mon_e.seq));
`endif
                end
            end
            prev_hold   <= sample_valid && !sample_ready && rst_n;
            prev_sample <= sample;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    // rmode: 0 = ready always high, 1 = ready low until after the last capture, 2 = random.
    task automatic run_seq(input int w_raw, input int nwin, input int rmode, input int rst_off);
        int W, P, c0, K, last, endc, rel, i, ph;
        bit aborted, in_run, is_clear, is_cap, en, do_rst, zero_next;
        W = (w_raw == 0) ? 1 : w_raw;
        P = W + S + 2;
        aborted = 0;
        zero_next = 0;
        @(posedge clk);
        #1;
        c0   = cyc;
        K    = c0 + 1;
        last = K + nwin * P - 1;
        endc = last + 3;
        for (int c = c0; c <= endc; c++) begin
            if (c != c0) begin
                @(posedge clk);
                #1;
            end
            rel      = c - K;
            in_run   = !aborted && c >= K && c <= last;
            i        = in_run ? rel / P : 0;
            ph       = in_run ? rel % P : -1;
            is_clear = in_run && ph == 0;
            is_cap   = in_run && ph == P - 1;
            en       = in_run && ph >= 1 && ph <= W;
            do_rst   = (rst_off >= 0) && (c == c0 + rst_off) && !aborted;

            start      = (c == c0) || (in_run && $urandom_range(3) == 0);
            window_len = is_clear ? WW'(w_raw) : WW'($urandom);
            continuous = is_cap ? (i < nwin - 1) : 1'($urandom_range(1));
            case (rmode)
                0:       sample_ready = 1'b1;
                1:       sample_ready = (c > last);
                default: sample_ready = 1'($urandom_range(1));
            endcase
            if (do_rst) sample_ready = 1'b0;
            rst_n = !do_rst;

            exp_clr   = is_clear;
            exp_en    = en;
            exp_busy  = in_run;
            exp_valid = m_pending;
            exp_ovr   = m_ovr;
            exp_zero  = zero_next;
            exp_cyc   = c;
            zero_next = do_rst;

            if (do_rst) begin
                m_pending = 0;
                m_ovr     = 0;
                m_seq     = 0;
                sb.delete();
                aborted   = 1;
            end else begin
                if (c == c0) m_ovr = 0;
                if (is_cap) begin
                    if (!m_pending || sample_ready) begin
                        m_pending = 1;
                        sb.push_back('{fsum(c), m_seq});
                    end else begin
                        m_ovr = 1;
                    end
                    m_seq++;
                end else if (m_pending && sample_ready) begin
                    m_pending = 0;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ro_clr", 64'(ro_clr), 64'd0);
        check("reset_ro_en", 64'(ro_en), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(sample_valid), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        check("reset_sample", 64'(sample), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_seq(8, 1, 0, -1);
        run_seq(0, 1, 0, -1);
        run_seq(8, 4, 0, -1);
        run_seq(8, 3, 1, -1);
        run_seq(8, 1, 0, 5);
        run_seq(8, 1, 0, -1);
        run_seq(1, 2, 2, -1);
        for (int n = 0; n < 25; n++) begin
            run_seq($urandom_range(0, 10), $urandom_range(1, 4), $urandom_range(0, 2),
                    ($urandom_range(7) == 0) ? $urandom_range(1, 20) : -1);
        end
        run_seq(2, 1, 0, -1);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ro_sample_sched.md
# ro_sample_sched

Measurement-window scheduler for the ring-oscillator power sensor. It clears the 16 RO counters, enables them for a programmable window, and waits for the counters and the 16-input adder tree to settle. It then captures the 36-bit tree sum into a sample register with a valid/ready handshake. It sits between the RO counter bank and the trace capture/UART path, and supports single-shot and continuous sampling.

## Interface
Parameters:
- WINDOW_W, 16, width of the window-length field.
- SUM_W, 36, width of the adder-tree sum (16 × 32-bit inputs).
- SETTLE_CYC, 4, idle cycles between end of window and capture; legal range 1..15.

Ports:
- clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin sampling; acted on only in IDLE.
- continuous  in  1  1 = re-arm after each capture; sampled at each CAPTURE.
- window_len  in  WINDOW_W  RO enable cycles per window; latched in CLEAR; 0 treated as 1.
- tree_sum  in  SUM_W  combinational sum from the adder tree.
- ro_clr  out  1  counter clear strobe, high for exactly the CLEAR cycle.
- ro_en  out  1  RO/counter enable, high for exactly the window length.
- sample  out  SUM_W  captured sum; stable while sample_valid=1.
- sample_valid  out  1  sample available.
- sample_ready  in  1  consumer accepts sample when valid & ready.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky; a capture was dropped because the previous sample was not yet accepted.

## Operation
- FSM states: IDLE, CLEAR, RUN, SETTLE, CAPTURE.
- IDLE:
  - start=1 → CLEAR.
  - start also clears overrun.
  - start in any other state is ignored.
- CLEAR:
  - ro_clr=1.
  - Latch max(window_len,1) into win_q.
  - Load down-counter with win_q.
  - → RUN.
- RUN:
  - ro_en=1.
  - Decrement the counter each cycle.
  - On the final cycle (count==1) → SETTLE and load the counter with SETTLE_CYC.
- SETTLE:
  - ro_en=0.
  - Decrement the counter.
  - At count==1 → CAPTURE.
- CAPTURE: one cycle.
  - If sample_valid=0, or the handshake completes this same cycle: sample<=tree_sum and sample_valid<=1.
  - Otherwise: keep the old sample and set overrun.
  - Next state: CLEAR if continuous=1, else IDLE.
- Handshake:
  - sample_valid clears on a cycle with valid & ready, unless CAPTURE loads a new sample that same cycle; in that case valid stays 1 with the new data.
  - sample must not change while valid=1 and no transfer occurs.
- All outputs are registered or a direct decode of registered state. No combinational path from an input to an output.
- Reset (any state, including mid-window) gives: state=IDLE, ro_en=0, ro_clr=0, sample=0, sample_valid=0, overrun=0, busy=0, counters=0.
- Dropping continuous mid-window completes the current window and capture, then returns to IDLE.
- window_len changes outside CLEAR have no effect on the window in progress.

## Timing
- start sampled high at edge k gives:
  - ro_clr high during cycle k+1.
  - ro_en high during cycles k+2 … k+1+W.
  - SETTLE during cycles k+2+W … k+1+W+S.
  - CAPTURE during cycle k+2+W+S.
  - sample_valid high from cycle k+3+W+S.
- Continuous period is W+S+2 cycles per sample, with no gap cycles.
- The consumer must accept within one period to avoid overrun.
- W=1 gives a single ro_en cycle; window_len=0 behaves identically.

## Configuration
- RO_SCHED_SEQNUM_EN defined:
  - Adds output sample_seq (16 bits), a sequence number captured alongside sample and held under the same valid rule.
  - The sequence number increments on every CAPTURE cycle, including dropped captures, and wraps 0xFFFF→0x0000.
  - Reset value 0.
  - Gaps in sample_seq expose overruns.
- RO_SCHED_SEQNUM_EN undefined: the port and counter are absent; all other behaviour is unchanged.

## Test plan
- Single-shot with window_len=8, SETTLE_CYC=4, tree_sum=36'h0_0000_1234, ready held 1, start at edge 0:
  - ro_clr high in cycle 1.
  - ro_en high in cycles 2–9.
  - sample=36'h0_0000_1234 and valid high in cycle 15 only.
  - busy low from cycle 15.
- window_len=0 → exactly one ro_en cycle; capture in cycle 7.
- Continuous with window_len=8 and ready=1 → a CLEAR pulse every 14 cycles; sample_valid rises every 14 cycles; overrun stays 0.
- Continuous with ready=0:
  - First sample is held unchanged.
  - Overrun is set at the second CAPTURE.
  - With RO_SCHED_SEQNUM_EN, a later accepted sample shows sample_seq jumping by more than 1.
- rst_n=0 asserted for 1 cycle during RUN (cycle 5) → next cycle all outputs are 0 and state is IDLE; a start afterwards runs a normal full window.
- start pulsed during RUN and during SETTLE → ignored; only one window occurs.
- Clearing continuous during RUN → that window captures, then the block returns to IDLE.
